// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I MEM stage: funct3 access encodings,
// the load result-select code and the bus FSM state type.
`timescale 1ns/1ps
package rv_mem_pkg;

    // funct3 encodings for loads and stores (stores only use B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // result_src value that marks a load in MEM
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
//
// Handshake: the master holds req=1 with we/addr/be/wdata stable until the
// slave answers with gnt=1 in the same cycle; that cycle transfers the
// request. A write completes at the grant. A read is answered later by a
// single rvalid=1 cycle carrying rdata, no earlier than one cycle after gnt.
`timescale 1ns/1ps
interface memory_stage_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane logic for the MEM stage: store strobes and
// replicated store data, load byte/halfword extraction with extension,
// and natural-alignment checking.
`timescale 1ns/1ps
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // pick the addressed byte and halfword out of the returned word
    always_comb begin
        rd_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // lane strobes, store replication, load extension and alignment per access size
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{rd_byte[7]}}, rd_byte}
                                             : {24'h0, rd_byte};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                load_data  = (funct3 == F3_H) ? {{16{rd_half[15]}}, rd_half}
                                              : {16'h0, rd_half};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                be         = 4'b1111;
                wdata      = store_data;
                load_data  = rdata;
                misaligned = |addr_lo;
            end
            // undefined funct3 values touch no lanes and return zero
            default: begin
                be         = 4'b0000;
                wdata      = 32'h0;
                load_data  = 32'h0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the pipelined RV32I core. Issues the EX/MEM access on the
// data-memory bus, stalls the front of the pipe while the access is in
// flight, flags misaligned accesses and times out lost read responses.
// Bus outputs are Mealy (same-cycle grant/response); state and the
// timeout counter are the only registers. TCNT_W must satisfy
// 2**TCNT_W > TIMEOUT_CYCLES and TIMEOUT_CYCLES must be at least 2.
`timescale 1ns/1ps
module memory_stage
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TCNT_W         = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_write_m,
    input  logic [1:0]           result_src_m,
    input  logic [31:0]          alu_result_m,
    input  logic [31:0]          srcb_forward_m,
    input  logic [2:0]           funct3_m,
    memory_stage_if.master       dmem,
    output logic [31:0]          load_data_m,
    output logic                 stall_m,
    output logic                 misaligned_m,
    output logic                 bus_err_m,
    output mem_state_t           state_dbg
);

    mem_state_t        state, state_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;

    logic        access;
    logic        is_load;
    logic        tcnt_last;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic        lane_misaligned;

    logic        req_c;
    logic        stall_c;
    logic        err_c;
    logic        mis_c;
    logic [31:0] ld_c;

    // a store that is also tagged as a load is handled as a store
    assign access    = mem_write_m | (result_src_m == RESULT_LOAD);
    assign is_load   = (result_src_m == RESULT_LOAD) & ~mem_write_m;
    assign tcnt_last = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

    load_store_align u_align (
        .funct3     (funct3_m),
        .addr_lo    (alu_result_m[1:0]),
        .store_data (srcb_forward_m),
        .rdata      (dmem.rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

    // next state, timeout counter update and same-cycle handshake outputs
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        err_c     = 1'b0;
        mis_c     = 1'b0;
        ld_c      = 32'h0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (lane_misaligned) begin
                        mis_c = 1'b1;
                    end else begin
                        req_c = 1'b1;
                        if (dmem.gnt) begin
                            if (is_load) begin
                                stall_c   = 1'b1;
                                state_nxt = RESP;
                                tcnt_nxt  = '0;
                            end
                        end else begin
                            stall_c   = 1'b1;
                            state_nxt = REQ;
                        end
                    end
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (dmem.gnt) begin
                    if (is_load) begin
                        stall_c   = 1'b1;
                        state_nxt = RESP;
                        tcnt_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            RESP: begin
                if (dmem.rvalid) begin
                    ld_c      = lane_load;
                    state_nxt = IDLE;
                    tcnt_nxt  = '0;
                end else if (tcnt_last) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                    tcnt_nxt  = '0;
                end else begin
                    stall_c  = 1'b1;
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tcnt_nxt  = '0;
            end
        endcase
    end

    // state and timeout counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // every output is forced low for as long as reset is held
    assign dmem.req     = rst & req_c;
    assign dmem.we      = rst & mem_write_m;
    assign dmem.addr    = rst ? {alu_result_m[31:2], 2'b00} : 32'h0;
    assign dmem.be      = rst ? lane_be : 4'b0000;
    assign dmem.wdata   = rst ? lane_wdata : 32'h0;
    assign load_data_m  = rst ? ld_c : 32'h0;
    assign stall_m      = rst & stall_c;
    assign misaligned_m = rst & mis_c;
    assign bus_err_m    = rst & err_c;
    assign state_dbg    = state;

endmodule

// File: tb/tb_memory_stage.sv
// Randomised bench for memory_stage: each access is driven cycle by cycle
// with chosen grant/response delays, and outputs are compared with a
// transaction-level model of lanes, extension and stall timing.
`timescale 1ns/1ps
module tb_memory_stage;
    import rv_mem_pkg::*;

    localparam int TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        mem_write_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m;
    logic [31:0] srcb_forward_m;
    logic [2:0]  funct3_m;
    logic [31:0] load_data_m;
    logic        stall_m;
    logic        misaligned_m;
    logic        bus_err_m;
    mem_state_t  state_dbg;

    memory_stage_if bus();

    memory_stage #(.TIMEOUT_CYCLES(TIMEOUT), .TCNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_write_m    (mem_write_m),
        .result_src_m   (result_src_m),
        .alu_result_m   (alu_result_m),
        .srcb_forward_m (srcb_forward_m),
        .funct3_m       (funct3_m),
        .dmem           (bus),
        .load_data_m    (load_data_m),
        .stall_m        (stall_m),
        .misaligned_m   (misaligned_m),
        .bus_err_m      (bus_err_m),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << size_of(f3)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] w;
        int n;
        n = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int n;
        logic [31:0] mask, val;
        n    = size_of(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
        val  = (rd >> (8 * (addr % 4))) & mask;
        if (!f3[2] && n < 4 && val[8*n-1]) val = val | ~mask;
        return val;
    endfunction

    function automatic logic [1:0] non_load_src();
        int v;
        v = $urandom_range(0, 2);
        return (v == 0) ? 2'b00 : (v == 1) ? 2'b10 : 2'b11;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        mem_write_m    = 1'b0;
        result_src_m   = 2'b00;
        alu_result_m   = $urandom;
        srcb_forward_m = $urandom;
        funct3_m       = F3_W;
        bus.gnt        = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = $urandom;
    endtask

    task automatic chk_cycle(input string tag, input logic e_req, input logic e_stall,
                             input logic [31:0] e_ld, input logic e_err, input logic e_mis);
        check({tag, ".req"},   32'(bus.req),      32'(e_req));
        check({tag, ".stall"}, 32'(stall_m),      32'(e_stall));
        check({tag, ".ld"},    load_data_m,       e_ld);
        check({tag, ".err"},   32'(bus_err_m),    32'(e_err));
        check({tag, ".mis"},   32'(misaligned_m), 32'(e_mis));
    endtask

    task automatic check_all_zero(input string tag);
        chk_cycle(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check({tag, ".we"},    32'(bus.we), 32'h0);
        check({tag, ".addr"},  bus.addr,    32'h0);
        check({tag, ".be"},    32'(bus.be), 32'h0);
        check({tag, ".wdata"}, bus.wdata,   32'h0);
        check({tag, ".state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // One access: gw = cycles without grant before the grant cycle,
    // rw = cycles after the grant until rvalid (0 = never answered).
    task automatic run_txn(input string tag, input logic wr, input logic ld,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int gw, input int rw,
                           input logic [31:0] rd);
        int n;
        logic acc, is_ld, mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_ld, exp_v;
        n     = size_of(f3);
        acc   = wr | ld;
        is_ld = ld & ~wr;
        mis   = acc && ((addr % n) != 0);
        e_be  = model_be(f3, addr);
        e_wd  = model_wdata(f3, data);
        e_ld  = model_load(f3, addr, rd);

        @(negedge clk);
        mem_write_m    = wr;
        result_src_m   = ld ? RESULT_LOAD : non_load_src();
        alu_result_m   = addr;
        srcb_forward_m = data;
        funct3_m       = f3;
        bus.gnt        = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = $urandom;
        if (!acc) begin
            #1;
            chk_cycle({tag, ".nop"}, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check({tag, ".nop.state"}, 32'(state_dbg), 32'(IDLE));
            return;
        end
        if (mis) begin
            #1;
            chk_cycle({tag, ".mis"}, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            return;
        end
        for (int c = 0; c <= gw; c++) begin
            if (c > 0) @(negedge clk);
            bus.gnt    = (c == gw);
            bus.rvalid = (c < gw) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rdata  = $urandom;
            #1;
            chk_cycle({tag, ".issue"}, 1'b1, (c < gw) || is_ld, 32'h0, 1'b0, 1'b0);
            check({tag, ".addr"}, bus.addr, addr & 32'hFFFF_FFFC);
            check({tag, ".be"},   32'(bus.be), 32'(e_be));
            check({tag, ".we"},   32'(bus.we), 32'(wr));
            if (wr) check({tag, ".wdata"}, bus.wdata, e_wd);
        end
        if (is_ld) begin
            if (rw != 0) exp_q.push_back(e_ld);
            for (int j = 0; j < TIMEOUT; j++) begin
                @(negedge clk);
                bus.gnt    = 1'b0;
                bus.rvalid = (rw != 0) && (j == rw - 1);
                bus.rdata  = bus.rvalid ? rd : $urandom;
                #1;
                if (bus.rvalid) begin
                    exp_v = exp_q.pop_front();
                    chk_cycle({tag, ".done"}, 1'b0, 1'b0, exp_v, 1'b0, 1'b0);
                    break;
                end else if (j == TIMEOUT - 1) begin
                    chk_cycle({tag, ".tmo"}, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
                end else begin
                    chk_cycle({tag, ".wait"}, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] ld_f3s[5];
        logic [2:0] st_f3s[3];
        ld_f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_f3s = '{F3_B, F3_H, F3_W};

        set_idle();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // directed cases
        run_txn("sb",   1'b1, 1'b0, F3_B,  32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'h0);
        run_txn("lh",   1'b0, 1'b1, F3_H,  32'h0000_2002, 32'h0,         2, 1, 32'h8001_1234);
        run_txn("lbu",  1'b0, 1'b1, F3_BU, 32'h0000_2001, 32'h0,         0, 1, 32'h0000_F000);
        run_txn("lw",   1'b0, 1'b1, F3_W,  32'h0000_2004, 32'h0,         1, 3, 32'hDEAD_BEEF);
        run_txn("lwm",  1'b0, 1'b1, F3_W,  32'h0000_3002, 32'h0,         0, 1, 32'h0);
        run_txn("shm",  1'b1, 1'b0, F3_H,  32'h0000_3001, 32'h1234_5678, 0, 0, 32'h0);
        run_txn("both", 1'b1, 1'b1, F3_H,  32'h0000_3002, 32'h1234_5678, 1, 0, 32'h0);
        run_txn("tmo",  1'b0, 1'b1, F3_W,  32'h0000_4000, 32'h0,         0, 0, 32'h0);
        run_txn("idle", 1'b0, 1'b0, F3_W,  32'h0,         32'h0,         0, 0, 32'h0);

        // reset asserted while a load waits for its response
        @(negedge clk);
        mem_write_m  = 1'b0;
        result_src_m = RESULT_LOAD;
        alu_result_m = 32'h0000_5000;
        funct3_m     = F3_W;
        bus.gnt      = 1'b1;
        bus.rvalid   = 1'b0;
        #1;
        check("rstresp.issue.stall", 32'(stall_m), 32'h1);
        @(negedge clk);
        bus.gnt = 1'b0;
        #1;
        check("rstresp.wait.stall", 32'(stall_m), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstresp.async");
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        #1;
        check("rstresp.late_rvalid.ld", load_data_m, 32'h0);
        repeat (2) @(negedge clk);
        check_all_zero("rstresp.held");
        set_idle();
        rst = 1'b1;
        run_txn("post_rst.idle", 1'b0, 1'b0, F3_W, 32'h0, 32'h0, 0, 0, 32'h0);
        run_txn("post_rst.lw",   1'b0, 1'b1, F3_W, 32'h0000_6008, 32'h0, 0, 1, 32'hCAFE_F00D);

        // randomised traffic
        for (int t = 0; t < 300; t++) begin
            int kind, gw, rw;
            logic [2:0] f3;
            kind = $urandom_range(0, 5);
            gw   = $urandom_range(0, 3);
            rw   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            case (kind)
                0, 1, 2: begin
                    f3 = ld_f3s[$urandom_range(0, 4)];
                    run_txn("rnd_ld", 1'b0, 1'b1, f3, $urandom, $urandom, gw, rw, $urandom);
                end
                3: begin
                    f3 = st_f3s[$urandom_range(0, 2)];
                    run_txn("rnd_st", 1'b1, 1'b0, f3, $urandom, $urandom, gw, 0, $urandom);
                end
                4: begin
                    f3 = st_f3s[$urandom_range(0, 2)];
                    run_txn("rnd_both", 1'b1, 1'b1, f3, $urandom, $urandom, gw, 0, $urandom);
                end
                default: begin
                    run_txn("rnd_nop", 1'b0, 1'b0, F3_W, $urandom, $urandom, 0, 0, $urandom);
                end
            endcase
        end

        check("exp_q.empty", 32'(exp_q.size()), 32'h0);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the pipelined RV32I core.
- Consumes the EX/MEM register outputs (address, store data, funct3, control) and drives a valid/ready data-memory bus.
- Generates byte-lane strobes and store data, and sign/zero-extends load data for the MEM/WB register.
- Asserts a stall to freeze IF..EX/MEM while a bus access is outstanding; detects misaligned accesses and watchdog timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in RESP before a bus error is declared (≥2).
- TCNT_W, 5: width of the timeout counter; must satisfy 2^TCNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_write_m  in  1  store instruction in MEM
- result_src_m  in  2  2'b01 = load (RESULT_LOAD), other values = no load
- alu_result_m  in  32  effective byte address
- srcb_forward_m  in  32  forwarded store data
- funct3_m  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- dmem_req  out  1  bus request valid
- dmem_gnt  in  1  bus accepts request this cycle
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {alu_result_m[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_rvalid  in  1  read response valid
- dmem_rdata  in  32  read response word
- load_data_m  out  32  extended load result, valid in the load completion cycle
- stall_m  out  1  hold upstream stages and EX/MEM
- misaligned_m  out  1  misaligned access, one cycle per instruction
- bus_err_m  out  1  load timed out

Behaviour:
- Reset (rst=0, async): state=IDLE, timeout counter=0. All outputs are 0 while reset is held. dmem_req drops immediately, even mid-transaction; any late rvalid after reset is ignored.
- access = mem_write_m | (result_src_m==RESULT_LOAD). If both are set, treat it as a store.
- Misaligned conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - On misalignment: misaligned_m=1 combinationally, no request, stall_m=0, load_data_m=0.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=3<<addr[1:0], wdata={2{data[15:0]}}.
  - SW: be=4'hF, wdata=data.
- Load extract:
  - Select the byte/halfword at addr[1:0] from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Loads drive dmem_be by the same rule as stores.
- The EX/MEM register holds its inputs while stall_m=1. dmem_addr/be/we/wdata are derived from those inputs, so they are stable while dmem_req && !dmem_gnt.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - dmem_req = access & aligned.
  - Store with gnt: completes this cycle, stall_m=0, stays in IDLE.
  - Load with gnt: go to RESP, stall_m=1.
  - No gnt: go to REQ, stall_m=1.
- REQ:
  - dmem_req=1.
  - Store with gnt: stall_m=0, go to IDLE.
  - Load with gnt: stall_m=1, go to RESP.
  - No gnt: stall_m=1, stay in REQ.
- RESP:
  - dmem_req=0; the counter increments each cycle.
  - rvalid: load_data_m = extended rdata, stall_m=0, counter cleared, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES-1 without rvalid: bus_err_m=1, load_data_m=0, stall_m=0, go to IDLE.
- Minimum load latency is 2 cycles (1 stall cycle). Zero-wait stores take 1 cycle.
- rvalid in IDLE/REQ is ignored. The bus guarantees rvalid ≥1 cycle after gnt.
- load_data_m is 0 in all non-completion cycles.

Decomposition:
- Package rv_mem_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU.
  - RESULT_LOAD=2'b01.
  - typedef enum logic[1:0] mem_state_t {IDLE,REQ,RESP}.
- Sub-module load_store_align: purely combinational; funct3 + addr[1:0] + store data + rdata -> be, wdata, load_data, misaligned.
- The FSM and timeout counter stay in memory_stage.

Test Plan:
- SB at addr 0x1003, data 0xAABBCCDD, gnt=1 immediately -> dmem_be=4'b1000, dmem_wdata=0xDDDDDDDD, dmem_addr=0x1000, stall_m=0 that cycle.
- LH at 0x2002, gnt after 2 cycles, rvalid 1 cycle later with rdata 0x8001_1234 -> stall_m high 3 cycles, then load_data_m=0xFFFF8001 with stall_m=0.
- LBU at 0x2001, rdata 0x0000_F000 -> load_data_m=0x000000F0. LW at 0x2004, rdata 0xDEADBEEF -> 0xDEADBEEF.
- LW at 0x3002 -> misaligned_m=1, dmem_req=0, stall_m=0. SH at 0x3001 -> same.
- LW granted, no rvalid, TIMEOUT_CYCLES=16 -> stall_m held 16 cycles, then bus_err_m=1 for 1 cycle, FSM back in IDLE.
- rst pulled low while in RESP -> dmem_req=0, stall_m=0 immediately. After release, the next LW completes normally and an rvalid arriving during reset is ignored.
